// File: rtl/depacketizer.sv
// Store-and-forward AXI-stream depacketizer: validates fixed-length packets,
// forwards good ones as an unframed stream and drops malformed ones whole.
module depacketizer #(
    parameter int DW = 512,
    parameter int AW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      packet_cycles,
    input  logic [DW-1:0]   axis_in_tdata,
    input  logic [DW/8-1:0] axis_in_tkeep,
    input  logic            axis_in_tlast,
    input  logic            axis_in_tvalid,
    output logic            axis_in_tready,
    output logic [DW-1:0]   axis_out_tdata,
    output logic            axis_out_tvalid,
    input  logic            axis_out_tready,
    output logic [31:0]     good_count,
    output logic [31:0]     bad_count,
    output logic            bad_strobe
);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [8:0]  CNT_ONE = 9'd1;

    typedef enum logic {RECV, DISCARD} rx_state_e;

    rx_state_e     state_q, state_d;
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   cptr_q, cptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [8:0]    cnt_q, cnt_d, cnt_next, pcyc;
    logic [7:0]    pc_q, pc_d;
    logic          err_q, err_d, err_next;
    logic [31:0]   good_q, good_d, bad_q, bad_d;
    logic          strobe_q, strobe_d;
    logic          full, in_fire, wr_en;

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] ram_q;
    logic          rd_vld_q, rd_en, pop;
    logic [1:0]    occ_q, occ_d;
    logic [2:0]    inflight;
    logic [DW-1:0] head_q, head_d, spare_q, spare_d;

    assign full           = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign axis_in_tready = !reset && ((state_q == DISCARD) || !full);
    assign in_fire        = axis_in_tvalid && axis_in_tready;

    assign axis_out_tvalid = (occ_q != 2'd0);
    assign axis_out_tdata  = head_q;
    assign good_count      = good_q;
    assign bad_count       = bad_q;
    assign bad_strobe      = strobe_q;

    // Expected length is latched on the first beat so it cannot shift mid-packet.
    assign pcyc     = (cnt_q == '0) ? {1'b0, packet_cycles} : {1'b0, pc_q};
    assign cnt_next = cnt_q + CNT_ONE;
    assign err_next = err_q | (axis_in_tkeep != '1);

    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        cptr_d   = cptr_q;
        cnt_d    = cnt_q;
        pc_d     = pc_q;
        err_d    = err_q;
        good_d   = good_q;
        bad_d    = bad_q;
        strobe_d = 1'b0;
        wr_en    = 1'b0;
        if (in_fire) begin
            if (state_q == RECV) begin
                wr_en  = 1'b1;
                wptr_d = wptr_q + PTR_ONE;
                cnt_d  = cnt_next;
                pc_d   = pcyc[7:0];
                err_d  = err_next;
                if (axis_in_tlast) begin
                    if ((cnt_next == pcyc) && !err_next) begin
                        cptr_d = wptr_q + PTR_ONE;
                        good_d = good_q + 32'd1;
                    end else begin
                        wptr_d   = cptr_q;
                        bad_d    = bad_q + 32'd1;
                        strobe_d = 1'b1;
                    end
                    cnt_d = '0;
                    err_d = 1'b0;
                end else if (cnt_next >= pcyc) begin
                    // >= also sends packet_cycles=0 straight to DISCARD, so such a
                    // packet can never wedge the buffer.
                    state_d = DISCARD;
                    err_d   = 1'b1;
                end
            end else if (axis_in_tlast) begin
                wptr_d   = cptr_q;
                bad_d    = bad_q + 32'd1;
                strobe_d = 1'b1;
                state_d  = RECV;
                cnt_d    = '0;
                err_d    = 1'b0;
            end
        end
    end

    // Read is issued only when the skid pair has room for it once the in-flight
    // RAM word lands, counting a same-cycle pop to keep 1 beat/cycle.
    assign pop      = axis_out_tvalid && axis_out_tready;
    assign inflight = {1'b0, occ_q} + {2'b00, rd_vld_q};
    assign rd_en    = (rptr_q != cptr_q) &&
                      ((inflight < 3'd2) || ((inflight == 3'd2) && pop));
    assign rptr_d   = rd_en ? (rptr_q + PTR_ONE) : rptr_q;

    always_comb begin
        occ_d   = occ_q;
        head_d  = head_q;
        spare_d = spare_q;
        case ({rd_vld_q, pop})
            2'b10: begin
                if (occ_q == 2'd0) head_d = ram_q;
                else               spare_d = ram_q;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = spare_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = ram_q;
                end else begin
                    head_d  = spare_q;
                    spare_d = ram_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RECV;
            wptr_q   <= '0;
            cptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            pc_q     <= '0;
            err_q    <= 1'b0;
            good_q   <= '0;
            bad_q    <= '0;
            strobe_q <= 1'b0;
            rd_vld_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            cptr_q   <= cptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            pc_q     <= pc_d;
            err_q    <= err_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            strobe_q <= strobe_d;
            rd_vld_q <= rd_en;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr_q[AW-1:0]] <= axis_in_tdata;
        if (rd_en) ram_q <= mem[rptr_q[AW-1:0]];
        head_q  <= head_d;
        spare_q <= spare_d;
    end

endmodule

// File: doc/depacketizer.md
Name: depacketizer

Overview:
Receive-side counterpart of the transmit packetizer. Accepts an AXI stream framed into fixed-length packets by TLAST and buffers each packet store-and-forward. Each packet is validated against the expected beat count and full TKEEP. Good packets are forwarded as a continuous unframed stream; malformed packets are discarded in full and counted.

Parameters:
DW, 512, data width in bits; TKEEP width is DW/8.
AW, 8, buffer address width; buffer depth = 2**AW beats.

Ports:
clk  input  1  single clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
packet_cycles  input  8  expected beats per packet; sampled on the first beat of each packet.
axis_in_tdata  input  DW  input data.
axis_in_tkeep  input  DW/8  input byte enables; every beat must be all-ones.
axis_in_tlast  input  1  marks the final beat of a packet.
axis_in_tvalid  input  1  input valid.
axis_in_tready  output  1  input ready.
axis_out_tdata  output  DW  unframed output data.
axis_out_tvalid  output  1  output valid.
axis_out_tready  input  1  output ready.
good_count  output  32  packets accepted; wraps modulo 2**32.
bad_count  output  32  packets dropped; wraps modulo 2**32.
bad_strobe  output  1  one-cycle pulse for each dropped packet.

Behaviour:
- Reset values: axis_in_tready=0, axis_out_tvalid=0, good_count=0, bad_count=0, bad_strobe=0. All pointers, beat counter and error flag are cleared. Reset mid-packet discards every buffered and partial packet.
- Circular buffer with three AW+1-bit pointers:
  - wptr: next write location.
  - cptr: commit pointer, the end of the last good packet.
  - rptr: read pointer.
- Full when wptr-rptr == 2**AW. axis_in_tready = !reset && !full. Exception: in DISCARD, axis_in_tready = 1.
- Input handshake is tvalid & tready.
- RX state machine, states RECV and DISCARD:
  - RECV:
    - Each beat is written at wptr, wptr is incremented, and beat count increments.
    - The error flag is set if tkeep != all-ones.
    - When the beat count reaches the sampled packet_cycles and tlast=0, the packet is overlong: set error and go to DISCARD.
  - On a tlast beat in RECV, the packet is good if and only if count == packet_cycles and the error flag is clear.
    - Good: cptr <= wptr+1; good_count++.
    - Bad: wptr <= cptr (rewind); bad_count++; bad_strobe pulses the following cycle.
    - Count and error flag reset for the next packet.
  - DISCARD: beats are accepted and not written. On tlast: wptr <= cptr, bad_count++, bad_strobe pulses, then return to RECV.
- packet_cycles = 0: every packet is bad.
- Constraint: packet_cycles <= 2**AW is required. A packet of that length always fits after the reader drains, so there is no deadlock.
- Read side:
  - Data is readable only while rptr != cptr.
  - Synchronous-read RAM feeds a 2-entry output skid register.
  - axis_out_tvalid first rises exactly 2 cycles after the committing tlast handshake when the output stage is empty.
  - Full throughput of 1 beat/cycle is sustained while axis_out_tready=1.
  - Data, once valid, is held stable until accepted.
- Simultaneous commit and read in the same cycle is legal. Full/empty evaluation uses registered pointers only.
- Rewinding never disturbs rptr or committed data.
- No TLAST on the output; packet boundaries are not preserved.

Test Plan:
1. packet_cycles=4, three back-to-back 4-beat packets with tlast on beat 4, out_tready=1 -> 12 beats out in order; good_count=3; bad_count=0; first out_tvalid 2 cycles after first tlast.
2. packet_cycles=4, one 3-beat packet then one 4-beat packet -> only the 4 beats of the second packet are output; bad_count=1; single bad_strobe pulse; good_count=1.
3. packet_cycles=4, one 7-beat packet (tlast on beat 7) followed by a good 4-beat packet -> DISCARD is entered after beat 4 with tready held at 1; bad_count=1; the next 4-beat packet is output intact.
4. packet_cycles=2, one packet whose beat 2 has tkeep=0x...FFFE -> dropped, no output, bad_count=1.
5. AW=3, packet_cycles=8, out_tready=0, send two packets -> first packet buffered; tready falls with 8 entries full. Then raise out_tready -> 16 beats out in order; good_count=2.
6. Assert reset for 1 cycle mid-packet with 5 committed beats unread -> out_tvalid=0 and counters=0 the next cycle. A fresh good packet then passes normally.
